sr_comp: RTL and testbench

Stream compressor for the SR datapath; the transmit-side counterpart of the SR decompressor. It accepts bursts of 64-bit beats, each carrying four signed 16-bit lanes, and reduces every lane to 8 bits. It packs two input beats into one 64-bit output word, so each burst is halved, and regenerates sop/eop framing on the output. It sits between the SR source and the link or buffer that later feeds the decompressor.

---
 rtl/sr_comp.sv | 144 ++++++++++++++
 tb/tb_sr_comp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_comp.sv
// sr_comp: packs two 4x16-bit beats into one 4x8-bit-per-lane 64-bit word and regenerates burst framing.
// Define SR_COMP_SAT_EN for signed saturation of each lane; otherwise lanes are truncated.
module sr_comp #(
    parameter int BURST_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [63:0] data_i,
    input  logic        sop_i,
    input  logic        eop_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [63:0] data_o,
    output logic        sop_o,
    output logic        eop_o,
    input  logic        ready_i,
    output logic        err_o
);
    localparam int BW    = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam int OW    = (BURST_LEN > 2) ? $clog2(BURST_LEN / 2) : 1;
    localparam int OLAST = BURST_LEN / 2 - 1;

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [OW-1:0]   ocnt_q, ocnt_d;
    logic [31:0]     half_q, half_d;
    logic            vld_q, vld_d;
    logic [63:0]     data_q, data_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic            err_q, err_d;
    logic [31:0]     red;
    logic            accept;
    logic            last;

`ifdef SR_COMP_SAT_EN
    always_comb begin
        red = '0;
        for (int i = 0; i < 4; i++) begin
            if ($signed(data_i[i*16 +: 16]) > 16'sd127)
                red[i*8 +: 8] = 8'h7F;
            else if ($signed(data_i[i*16 +: 16]) < -16'sd128)
                red[i*8 +: 8] = 8'h80;
            else
                red[i*8 +: 8] = data_i[i*16 +: 8];
        end
    end
`else
    logic unused_hi_bytes;
    assign unused_hi_bytes = ^{data_i[63:56], data_i[47:40], data_i[31:24], data_i[15:8]};
    always_comb begin
        red = '0;
        for (int i = 0; i < 4; i++) red[i*8 +: 8] = data_i[i*16 +: 8];
    end
`endif

    // Only S_LO can stall: a new word needs the output register free.
    assign ready_o = !rst && ((state_q != S_LO) || !vld_q || ready_i);
    assign accept  = valid_i && ready_o;
    assign last    = (bcnt_q == BW'(BURST_LEN - 1));

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        ocnt_d  = ocnt_q;
        half_d  = half_q;
        vld_d   = vld_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        err_d   = 1'b0;
        if (vld_q && ready_i) vld_d = 1'b0;
        if (accept) begin
            if (sop_i) begin
                // A sop always (re)starts a burst at beat 0, which is never the last beat.
                err_d   = (state_q != S_IDLE) || eop_i;
                half_d  = red;
                bcnt_d  = BW'(1);
                ocnt_d  = '0;
                state_d = S_LO;
            end else begin
                case (state_q)
                    S_IDLE: err_d = 1'b1;
                    S_HI: begin
                        err_d   = eop_i;
                        half_d  = red;
                        bcnt_d  = bcnt_q + 1'b1;
                        state_d = S_LO;
                    end
                    S_LO: begin
                        err_d  = (eop_i != last);
                        vld_d  = 1'b1;
                        data_d = {half_q, red};
                        sop_d  = (ocnt_q == '0);
                        eop_d  = (ocnt_q == OW'(OLAST));
                        if (last) begin
                            state_d = S_IDLE;
                            bcnt_d  = '0;
                            ocnt_d  = '0;
                        end else begin
                            state_d = S_HI;
                            bcnt_d  = bcnt_q + 1'b1;
                            ocnt_d  = (ocnt_q == OW'(OLAST)) ? '0 : ocnt_q + 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            ocnt_q  <= '0;
            half_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            ocnt_q  <= ocnt_d;
            half_q  <= half_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = vld_q;
    assign data_o  = data_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_sr_comp.sv
// Bench for sr_comp: burst-level reference model checked every cycle, plus literal spot checks.
module tb_sr_comp;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [63:0] data_i = '0;
    logic        sop_i = 1'b0;
    logic        eop_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        ready_o, valid_o, sop_o, eop_o, err_o;
    logic [63:0] data_o;

    int total = 0;
    int bad = 0;
    int words = 0, sops = 0, eops = 0, errs = 0;

    sr_comp #(.BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .sop_i(sop_i),
        .eop_i(eop_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
        .sop_o(sop_o), .eop_o(eop_o), .ready_i(ready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask

    // Reference model: a burst is a numbered sequence of beats; beat pairs form words.
    function automatic logic [7:0] mred(input logic [15:0] x);
        int v;
        logic [31:0] t;
        v = int'($signed(x));
`ifdef SR_COMP_SAT_EN
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`endif
        t = v;
        return t[7:0];
    endfunction

    function automatic logic [31:0] mredw(input logic [63:0] d);
        return {mred(d[63:48]), mred(d[47:32]), mred(d[31:16]), mred(d[15:0])};
    endfunction

    bit          m_inb = 0;
    int          m_idx = 0;
    logic [31:0] m_half = '0;
    bit          m_ov = 0, m_os = 0, m_oe = 0, m_err = 0;
    logic [63:0] m_od = '0;

    function automatic bit m_rdy();
        return !rst && !(m_inb && (m_idx % 2 == 1) && m_ov && !ready_i);
    endfunction

    always @(posedge clk) begin
        bit acc, lst;
        logic [31:0] r;
        if (rst) begin
            m_inb = 0; m_idx = 0; m_half = '0; m_ov = 0; m_od = '0;
            m_os = 0; m_oe = 0; m_err = 0;
        end else begin
            acc = valid_i && m_rdy();
            m_err = 0;
            if (m_ov && ready_i) m_ov = 0;
            if (acc) begin
                if (sop_i) begin
                    if (m_inb) m_err = 1;
                    m_inb = 1;
                    m_idx = 0;
                end
                if (!m_inb) m_err = 1;
                else begin
                    r = mredw(data_i);
                    if (m_idx % 2 == 0) m_half = r;
                    else begin
                        m_ov = 1;
                        m_od = {m_half, r};
                        m_os = (m_idx / 2 == 0);
                        m_oe = (m_idx / 2 == BL / 2 - 1);
                    end
                    lst = (m_idx == BL - 1);
                    if (eop_i != lst) m_err = 1;
                    if (lst) begin m_inb = 0; m_idx = 0; end
                    else m_idx++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready_o", ready_o, m_rdy());
        chk("valid_o", valid_o, m_ov);
        chk("data_o", data_o, m_od);
        chk("sop_o", sop_o, m_os);
        chk("eop_o", eop_o, m_oe);
        chk("err_o", err_o, m_err);
        if (valid_o && ready_i) begin
            words++;
            sops += int'(sop_o);
            eops += int'(eop_o);
        end
        if (err_o) errs++;
    end

    task automatic beat(input logic [63:0] d, input bit s, input bit e);
        int n = 0;
        valid_i = 1'b1; data_i = d; sop_i = s; eop_i = e;
        @(negedge clk);
        while (!ready_o && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL beat_timeout got=ready_o=0 want=ready_o=1 t=%0t", $time);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    endtask

    task automatic send_burst(input int first);
        for (int i = first; i < BL; i++)
            beat({$urandom, $urandom}, i == 0, i == BL - 1);
    endtask

    task automatic drain();
        ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        words = 0; sops = 0; eops = 0; errs = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data", data_o, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reduction pinned by hand on the first word of a burst
        beat(64'h0012_FF80_007F_0001, 1, 0);
        beat(64'h0100_FE00_FFFF_8000, 0, 0);
`ifdef SR_COMP_SAT_EN
        chk("pair_data", data_o, 64'h12807F01_7F80FF80);
`else
        chk("pair_data", data_o, 64'h12807F01_0000FF00);
`endif
        chk("pair_sop", sop_o, 1'b1);
        chk("pair_valid", valid_o, 1'b1);
        send_burst(2);
        drain();

        clr();
        send_burst(0);
        drain();
        chk("full_words", words, 8);
        chk("full_sops", sops, 1);
        chk("full_eops", eops, 1);
        chk("full_errs", errs, 0);

        clr();
        fork
            send_burst(0);
            begin
                int n = 0;
                while (words < 1 && n < 100) begin @(negedge clk); #1; n++; end
                ready_i = 1'b0;
                repeat (6) @(negedge clk);
                #1;
                chk("bp_ready", ready_o, 1'b0);
                chk("bp_valid", valid_o, 1'b1);
                ready_i = 1'b1;
            end
        join
        drain();
        chk("bp_words", words, 8);
        chk("bp_sops", sops, 1);
        chk("bp_eops", eops, 1);

        clr();
        for (int i = 0; i < 5; i++) beat({$urandom, $urandom}, i == 0, 0);
        send_burst(0);
        drain();
        chk("sop5_errs", errs, 1);
        chk("sop5_sops", sops, 2);
        chk("sop5_words", words, 10);

        clr();
        beat(64'h1111_2222_3333_4444, 0, 0);
        chk("idle_err", err_o, 1'b1);
        drain();
        chk("idle_words", words, 0);
        chk("idle_errs", errs, 1);

        for (int i = 0; i < 3; i++) beat({$urandom, $urandom}, i == 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_data", data_o, 64'h0);
        chk("mid_rst_sop", sop_o, 1'b0);
        chk("mid_rst_err", err_o, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        clr();
        send_burst(0);
        drain();
        chk("post_rst_words", words, 8);
        chk("post_rst_errs", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
